// File: rtl/mmio_pkg.sv
// Shared types and default address map for the CPU-to-peripheral MMIO bridge.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNMAPPED = 2'd1,
        ERR_ALIGN    = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_e;

    localparam logic [31:0] DM_LO  = 32'h0000_0000;
    localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
    localparam logic [31:0] TC0_LO = 32'h0000_7F00;
    localparam logic [31:0] TC0_HI = 32'h0000_7F0B;
    localparam logic [31:0] TC1_LO = 32'h0000_7F10;
    localparam logic [31:0] TC1_HI = 32'h0000_7F1B;
    localparam logic [31:0] INT_LO = 32'h0000_7F20;
    localparam logic [31:0] INT_HI = 32'h0000_7F23;

    // Channel order: 0 DM, 1 TC0, 2 TC1, 3 INT.
    localparam logic [127:0] DEF_SLV_LO = {INT_LO, TC1_LO, TC0_LO, DM_LO};
    localparam logic [127:0] DEF_SLV_HI = {INT_HI, TC1_HI, TC0_HI, DM_HI};

endpackage

// File: rtl/mmio_decode.sv
// Address decoder: lowest-index matching window wins; flags unmapped and word-only misuse.
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int unsigned          NSLV      = 4,
    parameter logic [32*NSLV-1:0]   SLV_LO    = {NSLV{32'h0}},
    parameter logic [32*NSLV-1:0]   SLV_HI    = {NSLV{32'h0}},
    parameter logic [NSLV-1:0]      WORD_ONLY = '0
) (
    input  logic [31:0]     addr_i,
    input  logic [3:0]      byteen_i,
    output logic [NSLV-1:0] hit_o,
    output logic            unmapped_o,
    output logic            align_err_o
);

    logic found;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hit_o = '0;
        found = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (!found && addr_i >= SLV_LO[32*i +: 32] && addr_i <= SLV_HI[32*i +: 32]) begin
                hit_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        unmapped_o  = !found;
        align_err_o = (|(hit_o & WORD_ONLY)) && (|byteen_i)
                      && ((addr_i[1:0] != 2'b00) || (byteen_i != 4'hF));
    end

endmodule

// File: rtl/mmio_bridge.sv
// Single-outstanding MMIO bridge: decodes a CPU access, runs a ready/wait handshake
// on one channel and reports data or an error code with a one-cycle completion pulse.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int unsigned          NSLV      = 4,
    parameter logic [32*NSLV-1:0]   SLV_LO    = {NSLV{32'h0}},
    parameter logic [32*NSLV-1:0]   SLV_HI    = {NSLV{32'h0}},
    parameter logic [NSLV-1:0]      WORD_ONLY = '0,
    parameter int unsigned          TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 p_req,
    input  logic [31:0]          p_addr,
    input  logic [3:0]           p_byteen,
    input  logic [31:0]          p_wdata,
    input  logic [31:0]          p_pc,
    output logic                 p_busy,
    output logic                 p_done,
    output logic [31:0]          p_rdata,
    output logic [1:0]           p_err,
    output logic [31:0]          p_err_pc,
    output logic [NSLV-1:0]      s_sel,
    output logic [31:0]          s_addr,
    output logic [3:0]           s_byteen,
    output logic [31:0]          s_wdata,
    input  logic [32*NSLV-1:0]   s_rdata,
    input  logic [NSLV-1:0]      s_ready
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_e          state_q;
    err_e            err_q;
    logic [NSLV-1:0] sel_q;
    logic [7:0]      cnt_q;
    logic [31:0]     addr_q, wdata_q, pc_q, rdata_q, err_pc_q;
    logic [3:0]      byteen_q;
    logic            done_q;

    logic [NSLV-1:0] hit;
    logic            unmapped, align_err;
    logic            sel_ready;
    logic [31:0]     sel_rdata;

    mmio_decode #(
        .NSLV      (NSLV),
        .SLV_LO    (SLV_LO),
        .SLV_HI    (SLV_HI),
        .WORD_ONLY (WORD_ONLY)
    ) u_decode (
        .addr_i      (p_addr),
        .byteen_i    (p_byteen),
        .hit_o       (hit),
        .unmapped_o  (unmapped),
        .align_err_o (align_err)
    );

    // Only the selected channel's ready and data are observed.
    assign sel_ready = |(s_ready & sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel_rdata = sel_rdata | (s_rdata[32*i +: 32] & {32{sel_q[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            err_q    <= ERR_NONE;
            sel_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            byteen_q <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            rdata_q  <= '0;
            err_pc_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (p_req) begin
                        addr_q   <= p_addr;
                        byteen_q <= p_byteen;
                        wdata_q  <= p_wdata;
                        pc_q     <= p_pc;
                        cnt_q    <= '0;
                        if (unmapped || align_err) begin
                            err_q    <= unmapped ? ERR_UNMAPPED : ERR_ALIGN;
                            rdata_q  <= '0;
                            err_pc_q <= p_pc;
                            done_q   <= 1'b1;
                            state_q  <= ST_RESP;
                        end else begin
                            sel_q   <= hit;
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        err_q    <= ERR_NONE;
                        rdata_q  <= (byteen_q == 4'h0) ? sel_rdata : 32'h0;
                        err_pc_q <= pc_q;
                        done_q   <= 1'b1;
                        sel_q    <= '0;
                        state_q  <= ST_RESP;
                    end else if (cnt_q == TO_CNT) begin
                        err_q    <= ERR_TIMEOUT;
                        rdata_q  <= '0;
                        err_pc_q <= pc_q;
                        done_q   <= 1'b1;
                        sel_q    <= '0;
                        state_q  <= ST_RESP;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign p_busy   = (state_q != ST_IDLE);
    assign p_done   = done_q;
    assign p_rdata  = rdata_q;
    assign p_err    = err_q;
    assign p_err_pc = err_pc_q;
    assign s_sel    = sel_q;
    assign s_addr   = addr_q;
    assign s_byteen = byteen_q;
    assign s_wdata  = wdata_q;

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised, sequential memory-mapped I/O bridge between the CPU memory stage and NSLV peripheral channels (data memory, timers, interrupt responder, future devices). It decodes each processor access against per-channel inclusive address windows and runs one outstanding transaction at a time with a ready/wait-state handshake. It also returns read data, or an error code, through a one-cycle completion pulse. Errors cover unmapped addresses, misaligned word-only accesses and slave timeouts; the exception unit consumes them.

## Interface
- NSLV, 4, number of slave channels (1..8)
- SLV_LO, {NSLV{32'h0}} packed, inclusive low bound per channel, channel i at [32*i+:32]
- SLV_HI, {NSLV{32'h0}} packed, inclusive high bound per channel
- WORD_ONLY, NSLV'b0, bit i set: channel i accepts only word-aligned full-word writes
- TIMEOUT, 15, max wait cycles in ACCESS before error (1..255)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- p_req  in  1  access request, sampled only in IDLE
- p_addr  in  32  byte address
- p_byteen  in  4  write byte enables; 4'b0000 = read
- p_wdata  in  32  write data
- p_pc  in  32  PC of requesting instruction
- p_busy  out  1  high whenever state != IDLE (pipeline stall)
- p_done  out  1  one-cycle completion pulse
- p_rdata  out  32  read data, valid with p_done
- p_err  out  2  error code, valid with p_done
- p_err_pc  out  32  latched PC of the completing access
- s_sel  out  NSLV  one-hot channel select, held through ACCESS
- s_addr  out  32  latched address
- s_byteen  out  4  latched byte enables
- s_wdata  out  32  latched write data
- s_rdata  in  32*NSLV  packed per-channel read data
- s_ready  in  NSLV  per-channel completion

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if p_req, latch addr/byteen/wdata/pc and decode. The lowest-index channel with SLV_LO<=addr<=SLV_HI wins.
- IDLE, no match: go to RESP with err=UNMAPPED; no s_sel.
- IDLE, WORD_ONLY channel with |byteen and (addr[1:0]!=0 or byteen!=4'hF): go to RESP with err=ALIGN; no s_sel.
- IDLE, otherwise: go to ACCESS with s_sel one-hot and wait counter cleared.
- ACCESS: if s_ready[sel], capture s_rdata[sel] (reads; writes capture 0) and go to RESP with err=NONE.
- ACCESS: else increment counter; when counter==TIMEOUT, go to RESP with err=TIMEOUT and rdata=0.
- RESP: p_done=1 for exactly one cycle, s_sel=0, next state IDLE.
- p_req is ignored while not in IDLE.
- Readiness on a non-selected channel is ignored.
- Error codes: 0 NONE, 1 UNMAPPED, 2 ALIGN, 3 TIMEOUT.
- Counter is 8 bits and saturates; it never wraps.

## Timing
- Reset: state=IDLE; s_sel, s_addr, s_byteen, s_wdata, p_rdata, p_err_pc all 0; p_err=0; p_done=0; p_busy=0; counter=0.
- Reset asserted mid-transaction aborts it: no p_done, s_sel drops asynchronously.
- Zero-wait slave (s_ready high in first ACCESS cycle): p_req at edge 0, s_sel in cycle 1, p_done in cycle 2. Minimum latency is 2 cycles.
- Each wait cycle adds 1. A timeout completes TIMEOUT+2 cycles after request.
- Decode errors: p_done in cycle 1 (IDLE→RESP directly).
- p_rdata, p_err and p_err_pc are registered. They hold until the next completion.
- p_busy is combinational from state. It is high in the request's acceptance cycle+1 onward, through RESP.
- Back-to-back: a new p_req is accepted in the IDLE cycle after RESP, so throughput is at most 1 access per 3 cycles.

## Structure
- Shared package mmio_pkg:
  - state encoding (IDLE/ACCESS/RESP)
  - error codes
  - default window constants: DM 0x0000_0000–0x0000_2FFF, TC0 0x0000_7F00–0x0000_7F0B, TC1 0x0000_7F10–0x0000_7F1B, INT 0x0000_7F20–0x0000_7F23
- Sub-module mmio_decode (combinational): addr, byteen, windows, WORD_ONLY in; one-hot hit, unmapped flag and align-error flag out.

## Test plan
- Read DM with default windows, addr 0x0000_0010, s_ready[0] tied high, s_rdata[0]=0xDEAD_BEEF -> p_done in cycle 2, p_rdata=0xDEAD_BEEF, p_err=0, s_sel=4'b0001 in cycle 1.
- Write TC1 with WORD_ONLY=4'b0110, addr 0x7F14, byteen 4'hF, s_ready[2] after 3 waits -> s_sel=4'b0100 for 4 cycles, p_done in cycle 5, p_err=0.
- Unmapped addr 0x0000_5000 with p_pc=0x3040 -> p_done in cycle 1, p_err=1, p_err_pc=0x3040, s_sel never asserted.
- Byte write to TC0 at 0x7F01 with byteen 4'b0010 -> p_err=2; s_sel stays 0.
- Timeout: TIMEOUT=4, INT read at 0x7F20, s_ready never set -> p_done at cycle 6, p_err=3, p_rdata=0.
- Reset mid-op: assert rst_n=0 in the second ACCESS cycle -> s_sel=0 immediately, no p_done. After release, a new DM read completes normally in 2 cycles.
